// File: rtl/uart_rx_framer.sv
// UART receive framer: synchronises the serial line, validates start/stop bits and emits
// single-cycle data-ready, framing-error and overrun pulses for the echo FIFO write port.
module uart_rx_framer #(
    parameter int CLOCK_FREQUENCY = 100_000_000,
    parameter int BAUD_RATE       = 115_200,
    parameter int DATA_BITS       = 8
) (
    input  logic                 sysclk,
    input  logic                 nrst_in,
    input  logic                 rx_serial_in,
    input  logic                 full_in,
    output logic [DATA_BITS-1:0] rx_data_out,
    output logic                 data_rdy_out,
    output logic                 frame_err_out,
    output logic                 overrun_out,
    output logic                 busy_out
);

    localparam int CLKS_PER_BIT = CLOCK_FREQUENCY / BAUD_RATE;
    localparam int HALF_BIT     = CLKS_PER_BIT / 2;
    localparam int CW           = $clog2(CLKS_PER_BIT);
    localparam int BW           = $clog2(DATA_BITS) + 1;

    localparam logic [CW-1:0] HALF_LAST = CW'(HALF_BIT - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] IDX_LAST  = BW'(DATA_BITS - 1);

    generate
        if (CLKS_PER_BIT < 4) begin : g_bad_baud
            $error("uart_rx_framer: CLKS_PER_BIT must be at least 4");
        end
    endgenerate

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BRK   = 3'd4
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [BW-1:0]         bit_idx_q, bit_idx_d;
    logic [DATA_BITS-1:0]  shreg_q, shreg_d;
    logic [DATA_BITS-1:0]  rx_data_q, rx_data_d;
    logic                  rdy_q, rdy_d;
    logic                  ferr_q, ferr_d;
    logic                  ovr_q, ovr_d;
    logic [1:0]            sync_q;
    logic                  rx_s;

    assign rx_s = sync_q[1];

    always_ff @(posedge sysclk or negedge nrst_in) begin
        if (!nrst_in) begin
            sync_q    <= 2'b11;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shreg_q   <= '0;
            rx_data_q <= '0;
            rdy_q     <= 1'b0;
            ferr_q    <= 1'b0;
            ovr_q     <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], rx_serial_in};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            bit_idx_q <= bit_idx_d;
            shreg_q   <= shreg_d;
            rx_data_q <= rx_data_d;
            rdy_q     <= rdy_d;
            ferr_q    <= ferr_d;
            ovr_q     <= ovr_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q + CW'(1);
        bit_idx_d = bit_idx_q;
        shreg_d   = shreg_q;
        rx_data_d = rx_data_q;
        rdy_d     = 1'b0;
        ferr_d    = 1'b0;
        ovr_d     = 1'b0;

        case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (!rx_s) begin
                    state_d = START;
                end
            end
            START: begin
                // Re-check the line at mid start bit; a short low pulse is just noise.
                if (cnt_q == HALF_LAST) begin
                    cnt_d     = '0;
                    bit_idx_d = '0;
                    state_d   = rx_s ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt_q == BIT_LAST) begin
                    cnt_d     = '0;
                    shreg_d   = {rx_s, shreg_q[DATA_BITS-1:1]};
                    bit_idx_d = bit_idx_q + BW'(1);
                    if (bit_idx_q == IDX_LAST) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                // Leaving at mid stop bit leaves half a bit to catch an immediate next start.
                if (cnt_q == BIT_LAST) begin
                    cnt_d = '0;
                    if (rx_s) begin
                        state_d = IDLE;
                        if (full_in) begin
                            ovr_d = 1'b1;
                        end else begin
                            rx_data_d = shreg_q;
                            rdy_d     = 1'b1;
                        end
                    end else begin
                        ferr_d  = 1'b1;
                        state_d = BRK;
                    end
                end
            end
            BRK: begin
                cnt_d = '0;
                if (rx_s) begin
                    state_d = IDLE;
                end
            end
            default: begin
                cnt_d   = '0;
                state_d = IDLE;
            end
        endcase
    end

    assign rx_data_out   = rx_data_q;
    assign data_rdy_out  = rdy_q;
    assign frame_err_out = ferr_q;
    assign overrun_out   = ovr_q;
    assign busy_out      = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_framer.sv
// Bench for uart_rx_framer at 10 clocks per bit: directed and random frames checked
// against a frame-level outcome model of the receiver.
module tb_uart_rx_framer;

    localparam int CPB = 10;

    logic       sysclk;
    logic       nrst_in;
    logic       rx_serial_in;
    logic       full_in;
    logic [7:0] rx_data_out;
    logic       data_rdy_out;
    logic       frame_err_out;
    logic       overrun_out;
    logic       busy_out;

    uart_rx_framer #(
        .CLOCK_FREQUENCY(1_000_000),
        .BAUD_RATE      (100_000),
        .DATA_BITS      (8)
    ) dut (
        .sysclk       (sysclk),
        .nrst_in      (nrst_in),
        .rx_serial_in (rx_serial_in),
        .full_in      (full_in),
        .rx_data_out  (rx_data_out),
        .data_rdy_out (data_rdy_out),
        .frame_err_out(frame_err_out),
        .overrun_out  (overrun_out),
        .busy_out     (busy_out)
    );

    initial sysclk = 1'b0;
    always #5 sysclk = ~sysclk;

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always @(posedge sysclk) cyc <= cyc + 1;

    // Observed pulse log
    int         rdy_cyc[$];
    logic [7:0] rdy_dat[$];
    int         ferr_cnt = 0;
    int         ovr_cnt  = 0;

    // Reference model: expected outcomes of the frames sent so far
    logic [7:0] exp_bytes[$];
    int         exp_ferr = 0;
    int         exp_ovr  = 0;
    logic [7:0] exp_last = 8'h00;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    logic prev_rdy = 1'b0, prev_ferr = 1'b0, prev_ovr = 1'b0;

    always @(negedge sysclk) begin
        if (data_rdy_out === 1'b1) begin
            rdy_cyc.push_back(cyc);
            rdy_dat.push_back(rx_data_out);
        end
        if (frame_err_out === 1'b1) ferr_cnt++;
        if (overrun_out === 1'b1) ovr_cnt++;
        check("no_double_pulse",
              {29'd0, prev_rdy & data_rdy_out, prev_ferr & frame_err_out, prev_ovr & overrun_out},
              32'd0);
        check("pulse_exclusive",
              32'(data_rdy_out) + 32'(frame_err_out) + 32'(overrun_out) <= 32'd1 ? 32'd1 : 32'd0,
              32'd1);
        prev_rdy  = data_rdy_out;
        prev_ferr = frame_err_out;
        prev_ovr  = overrun_out;
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge sysclk);
        #1;
    endtask

    task automatic idle(input int n);
        rx_serial_in = 1'b1;
        wait_cycles(n);
    endtask

    // Drives one frame; the line is left at the stop-bit level afterwards.
    task automatic send_frame(input logic [7:0] b, input logic stop, input logic full,
                              output int start_cyc);
        full_in      = full;
        start_cyc    = cyc;
        rx_serial_in = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 8; i++) begin
            rx_serial_in = b[i];
            wait_cycles(CPB);
        end
        rx_serial_in = stop;
        wait_cycles(CPB);
        full_in = 1'b0;
        if (!stop) exp_ferr++;
        else if (full) exp_ovr++;
        else begin
            exp_bytes.push_back(b);
            exp_last = b;
        end
    endtask

    task automatic check_events(input string tag);
        check({tag, "_rdy_count"}, rdy_dat.size(), exp_bytes.size());
        for (int i = 0; i < rdy_dat.size() && i < exp_bytes.size(); i++)
            check({tag, "_byte"}, {24'd0, rdy_dat[i]}, {24'd0, exp_bytes[i]});
        check({tag, "_ferr_count"}, ferr_cnt, exp_ferr);
        check({tag, "_ovr_count"}, ovr_cnt, exp_ovr);
        check({tag, "_rx_data"}, {24'd0, rx_data_out}, {24'd0, exp_last});
        check({tag, "_busy_idle"}, {31'd0, busy_out}, 32'd0);
        rdy_cyc.delete();
        rdy_dat.delete();
        exp_bytes.delete();
        ferr_cnt = 0;
        ovr_cnt  = 0;
        exp_ferr = 0;
        exp_ovr  = 0;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rx_data"}, {24'd0, rx_data_out}, 32'd0);
        check({tag, "_pulses"}, {29'd0, data_rdy_out, frame_err_out, overrun_out}, 32'd0);
        check({tag, "_busy"}, {31'd0, busy_out}, 32'd0);
    endtask

    initial begin
        int st, st0, lat, gap;
        logic [7:0] b;
        logic stop, full;

        nrst_in      = 1'b0;
        rx_serial_in = 1'b1;
        full_in      = 1'b0;
        wait_cycles(3);
        check_reset_outputs("reset");
        nrst_in = 1'b1;
        idle(5);

        // 1: ideal 0xA5 frame and latency
        send_frame(8'hA5, 1'b1, 1'b0, st);
        idle(10);
        lat = (rdy_cyc.size() > 0) ? rdy_cyc[0] - st : -1;
        check("t1_latency_97pm2", (lat >= 95 && lat <= 99) ? 32'd1 : 32'd0, 32'd1);
        check_events("t1");

        // 2: 3-cycle glitch, then 0x3C
        rx_serial_in = 1'b0;
        wait_cycles(3);
        idle(8);
        check("t2_glitch_busy", {31'd0, busy_out}, 32'd0);
        check_events("t2_glitch");
        send_frame(8'h3C, 1'b1, 1'b0, st);
        idle(10);
        check_events("t2");

        // 3: back-to-back 0x00, 0xFF, 0x81
        send_frame(8'h00, 1'b1, 1'b0, st0);
        send_frame(8'hFF, 1'b1, 1'b0, st);
        send_frame(8'h81, 1'b1, 1'b0, st);
        idle(10);
        check("t3_spacing_01", (rdy_cyc.size() == 3) ? rdy_cyc[1] - rdy_cyc[0] : 0, 32'd100);
        check("t3_spacing_12", (rdy_cyc.size() == 3) ? rdy_cyc[2] - rdy_cyc[1] : 0, 32'd100);
        check_events("t3");

        // 4: bad stop bit, break held 40 cycles, then 0x12
        send_frame(8'h55, 1'b0, 1'b0, st);
        rx_serial_in = 1'b0;
        wait_cycles(40);
        idle(10);
        check_events("t4_break");
        send_frame(8'h12, 1'b1, 1'b0, st);
        idle(10);
        check_events("t4");

        // 5: overrun with full_in high
        send_frame(8'h77, 1'b1, 1'b1, st);
        idle(10);
        check_events("t5");

        // 6: reset at bit 4 of 0xC3, then 0x5A
        b = 8'hC3;
        rx_serial_in = 1'b0;
        wait_cycles(CPB);
        for (int i = 0; i < 4; i++) begin
            rx_serial_in = b[i];
            wait_cycles(CPB);
        end
        rx_serial_in = b[4];
        wait_cycles(5);
        nrst_in = 1'b0;
        #1;
        check_reset_outputs("t6_async");
        exp_last = 8'h00;
        rx_serial_in = 1'b1;
        wait_cycles(3);
        nrst_in = 1'b1;
        idle(5);
        check_events("t6_after_reset");
        send_frame(8'h5A, 1'b1, 1'b0, st);
        idle(10);
        check_events("t6");

        // Random frames: random data, gaps, full and stop-bit faults
        for (int k = 0; k < 12; k++) begin
            b    = 8'($urandom_range(0, 255));
            full = ($urandom_range(0, 3) == 0);
            stop = ($urandom_range(0, 4) != 0);
            send_frame(b, stop, full, st);
            gap = stop ? $urandom_range(0, 5) : $urandom_range(3, 8);
            if (gap > 0) idle(gap);
        end
        idle(20);
        check_events("rand");

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
